// File: rtl/sky130_fd_io__vrefgen_seq.sv
// Reference-generator sequencer: ladder enable, timed cap precharge, buffered settle, qualified ready / sticky fault.
// All outputs registered one edge after the inputs that cause them; vsel_req waits (no ack) outside OFF->PRECHG and READY.
module sky130_fd_io__vrefgen_seq #(
  parameter int SEL_W      = 5,
  parameter int PRECHG_CYC = 64,
  parameter int SETTLE_CYC = 256,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             vsel_req,
  input  logic [SEL_W-1:0] vsel_in,
  input  logic             cap_ok,
  output logic             vsel_ack,
  output logic [SEL_W-1:0] vsel_out,
  output logic             ladder_en,
  output logic             prechg_en,
  output logic             buf_en,
  output logic             vref_ready,
  output logic             fault
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PRECHG = 3'd1,
    ST_SETTLE = 3'd2,
    ST_READY  = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRECHG_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYC - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   w_timer_nxt;
  logic               r_lowfilt;
  logic               w_lowfilt_nxt;
  logic [SEL_W-1:0]   w_vsel_nxt;
  logic               w_ack_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_lowfilt_nxt = 1'b0;
    w_vsel_nxt    = vsel_out;
    w_ack_nxt     = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_OFF;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_PRECHG;
          w_timer_nxt = PRE_LD;
          w_vsel_nxt  = vsel_in;
          w_ack_nxt   = vsel_req;
        end
        ST_PRECHG: begin
          if (r_timer == '0) begin
            w_state_nxt = ST_SETTLE;
            w_timer_nxt = SET_LD;
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_timer == '0) begin
            w_state_nxt = cap_ok ? ST_READY : ST_FAULT;
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end
        ST_READY: begin
          // Second consecutive low sample is a real loss of the cap node; it outranks a code change.
          if (!cap_ok && r_lowfilt) begin
            w_state_nxt = ST_FAULT;
          end else if (vsel_req) begin
            w_state_nxt = ST_SETTLE;
            w_timer_nxt = SET_LD;
            w_vsel_nxt  = vsel_in;
            w_ack_nxt   = 1'b1;
          end else begin
            w_lowfilt_nxt = !cap_ok;
          end
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default: begin
          w_state_nxt = ST_OFF;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_timer    <= '0;
      r_lowfilt  <= 1'b0;
      vsel_out   <= '0;
      vsel_ack   <= 1'b0;
      ladder_en  <= 1'b0;
      prechg_en  <= 1'b0;
      buf_en     <= 1'b0;
      vref_ready <= 1'b0;
      fault      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_lowfilt  <= w_lowfilt_nxt;
      vsel_out   <= w_vsel_nxt;
      vsel_ack   <= w_ack_nxt;
      // Output flops decode the next state so they line up with the state register.
      ladder_en  <= (w_state_nxt == ST_PRECHG) || (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_READY);
      prechg_en  <= (w_state_nxt == ST_PRECHG);
      buf_en     <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_READY);
      vref_ready <= (w_state_nxt == ST_READY);
      fault      <= (w_state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_sky130_fd_io__vrefgen_seq.sv
// Scoreboard bench: stimulus queues expected output edges and level snapshots; a negedge monitor pops and compares.
module tb_sky130_fd_io__vrefgen_seq;

  localparam int EV_ACK = 0, EV_PRE_R = 1, EV_PRE_F = 2, EV_BUF_R = 3,
                 EV_RDY_R = 4, EV_RDY_F = 5, EV_FLT_R = 6, EV_FLT_F = 7;

  typedef struct {
    int         kind;
    int         cyc;
    logic [4:0] dat;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [10:0] vec;
    string       name;
  } lvl_t;

  logic       clk, rst, enable, vsel_req, cap_ok;
  logic [4:0] vsel_in;
  logic       vsel_ack, ladder_en, prechg_en, buf_en, vref_ready, fault;
  logic [4:0] vsel_out;
  logic [10:0] outv;

  ev_t  exp_q[$];
  lvl_t lvl_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   e;
  bit   mon_en = 0;
  bit   done = 0;

  sky130_fd_io__vrefgen_seq #(
    .SEL_W(5), .PRECHG_CYC(4), .SETTLE_CYC(8), .CNT_W(10)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .vsel_req(vsel_req), .vsel_in(vsel_in),
    .cap_ok(cap_ok), .vsel_ack(vsel_ack), .vsel_out(vsel_out), .ladder_en(ladder_en),
    .prechg_en(prechg_en), .buf_en(buf_en), .vref_ready(vref_ready), .fault(fault)
  );

  assign outv = {vsel_out, vsel_ack, ladder_en, prechg_en, buf_en, vref_ready, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic string kname(input int k);
    case (k)
      EV_ACK:   return "ack";
      EV_PRE_R: return "prechg_rise";
      EV_PRE_F: return "prechg_fall";
      EV_BUF_R: return "buf_rise";
      EV_RDY_R: return "ready_rise";
      EV_RDY_F: return "ready_fall";
      EV_FLT_R: return "fault_rise";
      EV_FLT_F: return "fault_fall";
      default:  return "unknown";
    endcase
  endfunction

  function automatic logic [10:0] mkv(input logic [4:0] sel, input logic ack, input logic lad,
                                      input logic pre, input logic bf, input logic rdy, input logic flt);
    return {sel, ack, lad, pre, bf, rdy, flt};
  endfunction

  task automatic ev(input int k, input int c, input logic [4:0] d);
    ev_t x;
    x.kind = k; x.cyc = c; x.dat = d;
    exp_q.push_back(x);
  endtask

  task automatic lvl(input int c, input string n, input logic [10:0] v);
    lvl_t x;
    x.cyc = c; x.vec = v; x.name = n;
    lvl_q.push_back(x);
  endtask

  task automatic sb_evt(input int k, input logic [4:0] d);
    ev_t x;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL evt_%s: got %s at cyc %0d, expected no event", kname(k), kname(k), cyc);
    end else begin
      x = exp_q.pop_front();
      if (x.kind != k || x.cyc != cyc || (k == EV_ACK && x.dat != d)) begin
        errors++;
        $display("FAIL evt_%s: got %s cyc %0d dat %h, expected %s cyc %0d dat %h",
                 kname(x.kind), kname(k), cyc, d, kname(x.kind), x.cyc, x.dat);
      end
    end
  endtask

  // Monitor: level snapshots first, then output edges in a fixed order per cycle.
  initial begin
    logic p_pre, p_buf, p_rdy, p_flt;
    lvl_t l;
    ev_t  x;
    p_pre = 1'b0; p_buf = 1'b0; p_rdy = 1'b0; p_flt = 1'b0;
    forever begin
      @(negedge clk);
      while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
        l = lvl_q.pop_front();
        checks++;
        if (outv !== l.vec) begin
          errors++;
          $display("FAIL lvl_%s: cyc %0d got %b expected %b", l.name, cyc, outv, l.vec);
        end
      end
      if (mon_en) begin
        if (vsel_ack === 1'b1)                  sb_evt(EV_ACK, vsel_out);
        if (prechg_en === 1'b1 && !p_pre)       sb_evt(EV_PRE_R, 5'h0);
        if (prechg_en === 1'b0 && p_pre)        sb_evt(EV_PRE_F, 5'h0);
        if (buf_en === 1'b1 && !p_buf)          sb_evt(EV_BUF_R, 5'h0);
        if (vref_ready === 1'b1 && !p_rdy)      sb_evt(EV_RDY_R, 5'h0);
        if (vref_ready === 1'b0 && p_rdy)       sb_evt(EV_RDY_F, 5'h0);
        if (fault === 1'b1 && !p_flt)           sb_evt(EV_FLT_R, 5'h0);
        if (fault === 1'b0 && p_flt)            sb_evt(EV_FLT_F, 5'h0);
        p_pre = (prechg_en === 1'b1);
        p_buf = (buf_en === 1'b1);
        p_rdy = (vref_ready === 1'b1);
        p_flt = (fault === 1'b1);
      end
      if (done) begin
        while (exp_q.size() > 0) begin
          x = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_%s: not seen, expected at cyc %0d", kname(x.kind), x.cyc);
        end
        while (lvl_q.size() > 0) begin
          l = lvl_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_lvl_%s: snapshot at cyc %0d never taken", l.name, l.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; vsel_req = 1'b0; vsel_in = 5'h00; cap_ok = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    mon_en = 1'b1;
    lvl(cyc, "reset", 11'h000);
    #6 rst = 1'b0;
    tick(1);

    // Power-up: 4 precharge cycles then 8 settle cycles
    vsel_in = 5'h0A; cap_ok = 1'b1; enable = 1'b1;
    e = cyc + 1;
    ev(EV_PRE_R, e, 0); ev(EV_PRE_F, e + 4, 0); ev(EV_BUF_R, e + 4, 0); ev(EV_RDY_R, e + 12, 0);
    lvl(e + 2, "pwrup_prechg", mkv(5'h0A, 0, 1, 1, 0, 0, 0));
    lvl(e + 12, "pwrup_ready", mkv(5'h0A, 0, 1, 0, 1, 1, 0));
    tick(13);

    // Single-cycle cap_ok glitch is filtered
    cap_ok = 1'b0;
    tick(1);
    cap_ok = 1'b1;
    lvl(cyc + 2, "glitch1_ready", mkv(5'h0A, 0, 1, 0, 1, 1, 0));
    tick(3);

    // Code change from READY: resettle only, no precharge
    vsel_in = 5'h13; vsel_req = 1'b1;
    e = cyc + 1;
    ev(EV_ACK, e, 5'h13); ev(EV_RDY_F, e, 0); ev(EV_RDY_R, e + 8, 0);
    lvl(e + 4, "codechg_settle", mkv(5'h13, 0, 1, 0, 1, 0, 0));
    tick(1);
    vsel_req = 1'b0;
    tick(8);

    // Two low cycles; request on the second one loses to the fault
    cap_ok = 1'b0;
    tick(1);
    vsel_in = 5'h05; vsel_req = 1'b1;
    e = cyc + 1;
    ev(EV_RDY_F, e, 0); ev(EV_FLT_R, e, 0);
    lvl(e, "glitch2_fault", mkv(5'h13, 0, 0, 0, 0, 0, 1));
    lvl(e + 3, "fault_sticky", mkv(5'h13, 0, 0, 0, 0, 0, 1));
    tick(1);
    vsel_req = 1'b0;
    tick(3);
    enable = 1'b0;
    e = cyc + 1;
    ev(EV_FLT_F, e, 0);
    lvl(e, "fault_clear", mkv(5'h13, 0, 0, 0, 0, 0, 0));
    tick(2);

    // Request raised during PRECHG is held off until the first READY cycle
    cap_ok = 1'b1; vsel_in = 5'h07; enable = 1'b1;
    e = cyc + 1;
    ev(EV_PRE_R, e, 0); ev(EV_PRE_F, e + 4, 0); ev(EV_BUF_R, e + 4, 0); ev(EV_RDY_R, e + 12, 0);
    ev(EV_ACK, e + 13, 5'h11); ev(EV_RDY_F, e + 13, 0); ev(EV_RDY_R, e + 21, 0);
    lvl(e + 8, "req_wait_settle", mkv(5'h07, 0, 1, 0, 1, 0, 0));
    lvl(e + 21, "req_done_ready", mkv(5'h11, 0, 1, 0, 1, 1, 0));
    tick(2);
    vsel_in = 5'h11; vsel_req = 1'b1;
    tick(12);
    vsel_req = 1'b0;
    tick(8);

    // Open cap: cap_ok never good
    enable = 1'b0;
    ev(EV_RDY_F, cyc + 1, 0);
    tick(2);
    cap_ok = 1'b0; enable = 1'b1;
    e = cyc + 1;
    ev(EV_PRE_R, e, 0); ev(EV_PRE_F, e + 4, 0); ev(EV_BUF_R, e + 4, 0); ev(EV_FLT_R, e + 12, 0);
    lvl(e + 11, "opencap_settle", mkv(5'h11, 0, 1, 0, 1, 0, 0));
    lvl(e + 12, "opencap_fault", mkv(5'h11, 0, 0, 0, 0, 0, 1));
    tick(13);
    enable = 1'b0;
    ev(EV_FLT_F, cyc + 1, 0);
    tick(2);

    // Pending request acked on OFF->PRECHG; async reset in SETTLE; full sequence repeats
    cap_ok = 1'b1; vsel_in = 5'h1F; vsel_req = 1'b1; enable = 1'b1;
    e = cyc + 1;
    ev(EV_ACK, e, 5'h1F); ev(EV_PRE_R, e, 0); ev(EV_PRE_F, e + 4, 0); ev(EV_BUF_R, e + 4, 0);
    tick(1);
    vsel_req = 1'b0;
    tick(5);
    #2 rst = 1'b1;
    lvl(cyc, "rst_async", 11'h000);
    #4 rst = 1'b0;
    e = cyc + 1;
    ev(EV_PRE_R, e, 0); ev(EV_PRE_F, e + 4, 0); ev(EV_BUF_R, e + 4, 0); ev(EV_RDY_R, e + 12, 0);
    lvl(e + 12, "rst_resume", mkv(5'h1F, 0, 1, 0, 1, 1, 0));
    tick(13);

    enable = 1'b0;
    ev(EV_RDY_F, cyc + 1, 0);
    tick(3);
    done = 1'b1;
    tick(20);
    $display("FAIL monitor_end: summary not reached, expected within 1 cycle");
    $fatal(1);
  end

endmodule

// File: doc/sky130_fd_io__vrefgen_seq.md
Name: sky130_fd_io__vrefgen_seq

Overview:
- Digital sequencer for the on-chip reference generator that drives the external reference capacitor (cpos/cneg).
- It owns the ladder-tap select code and enables the ladder.
- It runs a timed precharge of the external cap through the analog mux path, then a settle window.
- It reports a qualified vref_ready, or a sticky fault if the cap node never reaches target (open or shorted cap).

Parameters:
SEL_W, 5, width of ladder tap select code
PRECHG_CYC, 64, cycles precharge switch is held closed (>=1)
SETTLE_CYC, 256, cycles of buffered settle before cap_ok is judged (>=1)
CNT_W, 10, timer width; must hold max(PRECHG_CYC,SETTLE_CYC)-1

Ports:
clk  input  1  sequencer clock
rst  input  1  asynchronous active-high reset
enable  input  1  level enable for the reference; low forces OFF
vsel_req  input  1  request to load a new tap code; held high until vsel_ack
vsel_in  input  SEL_W  requested tap code; stable while vsel_req high
cap_ok  input  1  synchronized comparator: cap node within window of target
vsel_ack  output  1  one-cycle pulse, code accepted
vsel_out  output  SEL_W  registered tap code to ladder
ladder_en  output  1  ladder bias enable
prechg_en  output  1  closes low-impedance precharge switch onto cpos
buf_en  output  1  enables reference buffer driving cpos
vref_ready  output  1  reference settled and within window
fault  output  1  sticky fault flag

Behaviour:
- States: OFF, PRECHG, SETTLE, READY, FAULT. All outputs are registered.
- Reset (async, rst=1):
  - state=OFF, timer=0, lowfilt=0, vsel_out=0.
  - All single-bit outputs are 0.
- OFF:
  - All enables are 0; vsel_out holds its value.
  - If enable=1: vsel_out<=vsel_in, timer<=PRECHG_CYC-1, go to PRECHG.
  - A pending vsel_req is acked in that same transition cycle.
- PRECHG:
  - ladder_en=1, prechg_en=1, buf_en=0.
  - Timer decrements each cycle. When timer==0: go to SETTLE and set timer<=SETTLE_CYC-1.
  - Dwell is exactly PRECHG_CYC cycles.
- SETTLE:
  - ladder_en=1, buf_en=1, prechg_en=0.
  - Dwell is exactly SETTLE_CYC cycles.
  - At timer==0: if cap_ok=1, go to READY; else go to FAULT.
- READY:
  - vref_ready=1, ladder_en=1, buf_en=1.
  - Glitch filter: cap_ok=0 on 2 consecutive cycles -> FAULT. A single low cycle is ignored and lowfilt clears on cap_ok=1.
  - vsel_req=1 (and no fault this cycle): vsel_out<=vsel_in, vsel_ack=1, vref_ready<=0, timer<=SETTLE_CYC-1, go to SETTLE. No re-precharge.
- FAULT:
  - fault=1; ladder_en, buf_en, prechg_en, vref_ready = 0.
  - Sticky until enable=0 -> OFF with fault cleared.
- Handshake:
  - vsel_req is acked only in READY or on the OFF->PRECHG transition.
  - In PRECHG/SETTLE the requester waits (no ack).
  - vsel_ack never asserts on consecutive cycles. The requester must drop vsel_req the cycle after ack.
- enable=0 in any state:
  - Next state is OFF; all enables, vref_ready and fault go to 0.
  - No ack is issued that cycle.
- Priority, highest first: rst > enable=0 > fault detection > vsel_req.
- Timer never wraps: it is loaded only on state entry and holds at 0 outside timed states.
- vref_ready deasserts the same edge the state leaves READY.

Test Plan (bench params PRECHG_CYC=4, SETTLE_CYC=8, SEL_W=5):
- Power-up:
  - Stimulus: rst pulse mid-cycle, then enable=1, vsel_in=5'h0A, cap_ok=1.
  - Required: prechg_en high exactly 4 cycles, then buf_en; vref_ready rises 12 cycles after enable is sampled; vsel_out=0x0A.
- Open cap:
  - Stimulus: cap_ok held 0 through SETTLE.
  - Required: fault=1 and ladder_en=0 at cycle 12, no vref_ready. Fault holds with enable=1; clears one cycle after enable=0.
- Code change:
  - Stimulus: in READY, vsel_req with vsel_in=0x13.
  - Required: single vsel_ack pulse, vsel_out=0x13, vref_ready low for 8 cycles, prechg_en stays 0.
- Request during PRECHG:
  - Stimulus: vsel_req held high during PRECHG.
  - Required: no ack until READY; ack on the first READY cycle.
- Glitch filter:
  - Stimulus: in READY, cap_ok low 1 cycle.
  - Required: stays READY.
  - Stimulus: cap_ok low 2 cycles coinciding with vsel_req.
  - Required: FAULT, no ack.
- Reset mid-operation:
  - Stimulus: rst asserted during SETTLE.
  - Required: outputs 0 immediately (async). After release with enable=1, full 4+8 sequence repeats.
